// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: queues commands, drives registered ALU inputs,
// waits for them to settle, then captures one result word behind a valid/ready port.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  output logic                     alu_s1,
  output logic                     alu_s0,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  input  logic [3:0]               alu_sum,
  input  logic                     alu_carry,
  input  logic                     alu_greater,
  input  logic                     alu_lesser,
  input  logic                     alu_equal,
  input  logic [3:0]               alu_and,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [1:0]               res_op,
  output logic [3:0]               res_data,
  output logic                     res_flag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

  state_t          state, state_next;
  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [SW-1:0]   settle_cnt, settle_next;
  logic            push, pop, load, capture;
  logic [9:0]      head;
  logic [3:0]      packed_data;
  logic            packed_flag;

  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    pop         = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop         = 1'b1;
          load        = 1'b1;
          settle_next = SW'(SETTLE);
          state_next  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == SW'(1)) state_next = CAPTURE;
        else                      settle_next = settle_cnt - SW'(1);
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        // The next queued command is loaded on the same edge the result is taken.
        if (res_valid && res_ready) begin
          if (count != '0) begin
            pop         = 1'b1;
            load        = 1'b1;
            settle_next = SW'(SETTLE);
            state_next  = DRIVE;
          end else begin
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    packed_data = 4'h0;
    packed_flag = 1'b0;
    case ({alu_s1, alu_s0})
      2'b00, 2'b01: begin
        packed_data = alu_sum;
        packed_flag = alu_carry;
      end
      2'b10:   packed_data = {1'b0, alu_greater, alu_lesser, alu_equal};
      default: packed_data = alu_and;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  // Ready is registered so a pop from a full queue cannot open the input that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      cmd_ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_s1 <= 1'b0;
      alu_s0 <= 1'b0;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
    end else if (load) begin
      {alu_s1, alu_s0, alu_a, alu_b} <= head;
    end else if (state_next == IDLE) begin
      alu_s1 <= 1'b0;
      alu_s0 <= 1'b0;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_op    <= 2'b00;
      res_data  <= 4'h0;
      res_flag  <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_op    <= {alu_s1, alu_s0};
      res_data  <= packed_data;
      res_flag  <= packed_flag;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and an
// in-order result model computed from plain arithmetic on each accepted command.
module tb_alu_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       alu_s1, alu_s0;
  logic [3:0] alu_a, alu_b, alu_sum, alu_and;
  logic       alu_carry, alu_greater, alu_lesser, alu_equal;
  logic       res_valid, res_ready;
  logic [1:0] res_op;
  logic [3:0] res_data;
  logic       res_flag, busy;
  logic [2:0] fifo_count;
  logic [4:0] addsub;

  int checks = 0;
  int errors = 0;
  bit producer_done = 1'b1;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic       flag;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  always #5 clk = ~clk;

  // The ALU being fed by the sequencer.
  assign addsub      = alu_s0 ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_sum     = addsub[3:0];
  assign alu_carry   = addsub[4];
  assign alu_greater = alu_a > alu_b;
  assign alu_lesser  = alu_a < alu_b;
  assign alu_equal   = alu_a == alu_b;
  assign alu_and     = alu_a & alu_b;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sum(alu_sum), .alu_carry(alu_carry), .alu_greater(alu_greater),
    .alu_lesser(alu_lesser), .alu_equal(alu_equal), .alu_and(alu_and),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_data(res_data),
    .res_flag(res_flag), .busy(busy), .fifo_count(fifo_count)
  );

  function automatic res_t ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    res_t r;
    int ia, ib, s;
    ia = int'(a);
    ib = int'(b);
    r.op = op;
    r.flag = 1'b0;
    r.data = 4'h0;
    case (op)
      2'd0: begin s = ia + ib; r.data = 4'(s % 16); r.flag = (s > 15); end
      2'd1: begin s = ia - ib; r.data = 4'((s + 16) % 16); r.flag = (ia < ib); end
      2'd2: r.data = {1'b0, ia > ib, ia < ib, ia == ib};
      default: r.data = a & b;
    endcase
    return r;
  endfunction

  task automatic offer(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      cmd_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("[TB] FAIL offer_timeout: cmd_ready=%0b required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      exp_q.push_back(ref_result(op, a, b));
    end
  endtask

  task automatic stop_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Collects handshaken results, optionally with random backpressure and a rate check.
  task automatic drain(input bit random_ready, input int max_cycles, input bit check_rate);
    bit   stalled;
    res_t held;
    int   last_hs;
    int   cyc;
    stalled = 1'b0;
    held = '0;
    last_hs = -1;
    for (cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (res_valid !== 1'b1 || {res_op, res_data, res_flag} !== held) begin
          errors++;
          $display("[TB] FAIL hold_stable: valid=%0b op=%0d data=%h flag=%0b required valid=1 op=%0d data=%h flag=%0b",
                   res_valid, res_op, res_data, res_flag, held.op, held.data, held.flag);
        end
      end
      if (producer_done && !busy && !res_valid && !cmd_valid) break;
      res_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid && res_ready) begin
        obs_q.push_back({res_op, res_data, res_flag});
        if (check_rate && last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != SETTLE + 2) begin
            errors++;
            $display("[TB] FAIL throughput: interval=%0d required %0d", cyc - last_hs, SETTLE + 2);
          end
        end
        last_hs = cyc;
      end
      stalled = res_valid && !res_ready;
      held = {res_op, res_data, res_flag};
    end
    res_ready = 1'b0;
    checks++;
    if (cyc >= max_cycles) begin
      errors++;
      $display("[TB] FAIL drain_timeout: cycles=%0d limit=%0d", cyc, max_cycles);
    end
  endtask

  task automatic compare_queues(input string name);
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: results=%0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s_result[%0d]: op=%0d data=%h flag=%0b required op=%0d data=%h flag=%0b",
                 name, i, obs_q[i].op, obs_q[i].data, obs_q[i].flag, exp_q[i].op, exp_q[i].data, exp_q[i].flag);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({cmd_ready, alu_s1, alu_s0, alu_a, alu_b, res_valid, res_op, res_data, res_flag, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL %s_outputs: ready=%0b s=%0b%0b a=%h b=%h valid=%0b op=%0d data=%h flag=%0b busy=%0b required all 0",
               name, cmd_ready, alu_s1, alu_s0, alu_a, alu_b, res_valid, res_op, res_data, res_flag, busy);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL %s_count: fifo_count=%0d required 0", name, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_a = 4'h0;
    cmd_b = 4'h0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: cmd_ready=%0b required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  // One command into an idle unit: latency, packing, then handshake.
  task automatic run_one(input string name, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] want_data, input logic want_flag);
    int n;
    offer(op, a, b);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n != SETTLE + 2) begin
      errors++;
      $display("[TB] FAIL %s_latency: edges=%0d required %0d", name, n, SETTLE + 2);
    end
    checks++;
    if (res_op !== op || res_data !== want_data || res_flag !== want_flag) begin
      errors++;
      $display("[TB] FAIL %s_result: op=%0d data=%h flag=%0b required op=%0d data=%h flag=%0b",
               name, res_op, res_data, res_flag, op, want_data, want_flag);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_clear: res_valid=%0b required 0", name, res_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0) begin
      errors++;
      $display("[TB] FAIL %s_idle: busy=%0b alu_a=%h alu_b=%h required 0 0 0", name, busy, alu_a, alu_b);
    end
    exp_q.delete();
  endtask

  task automatic test_directed();
    run_one("add_9_8", 2'd0, 4'h9, 4'h8, 4'h1, 1'b1);
    run_one("sub_5_3", 2'd1, 4'h5, 4'h3, 4'h2, 1'b0);
    run_one("sub_3_5", 2'd1, 4'h3, 4'h5, 4'hE, 1'b1);
    run_one("cmp_7_7", 2'd2, 4'h7, 4'h7, 4'b0001, 1'b0);
    run_one("cmp_9_3", 2'd2, 4'h9, 4'h3, 4'b0100, 1'b0);
    run_one("and_c_a", 2'd3, 4'hC, 4'hA, 4'h8, 1'b0);
  endtask

  task automatic test_fill();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      offer(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    stop_cmd();
    checks++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4 || res_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_full: ready=%0b count=%0d valid=%0b required 0 4 1", cmd_ready, fifo_count, res_valid);
    end
    cmd_valid = 1'b1;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_a = 4'($urandom_range(0, 15));
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_blocked: count=%0d ready=%0b required 4 0", fifo_count, cmd_ready);
    end
    cmd_valid = 1'b0;
    producer_done = 1'b1;
    drain(1'b0, 200, 1'b1);
    compare_queues("fill");
  endtask

  task automatic test_back_to_back();
    producer_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          offer(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) stop_cmd();
        end
        stop_cmd();
        producer_done = 1'b1;
      end
      drain(1'b1, 3000, 1'b0);
    join
    compare_queues("random");
  endtask

  task automatic test_reset_mid();
    logic [3:0] as [4];
    int n;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      as[i] = 4'($urandom_range(1, 15));
      offer(2'($urandom_range(0, 3)), as[i], 4'($urandom_range(0, 15)));
    end
    stop_cmd();
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || res_valid !== 1'b0 || alu_a !== as[1]) begin
      errors++;
      $display("[TB] FAIL pre_reset: count=%0d valid=%0b alu_a=%h required 2 0 %h", fifo_count, res_valid, alu_a, as[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: valid=%0b busy=%0b required 0 0", res_valid, busy);
    end
    run_one("add_1_1", 2'd0, 4'h1, 4'h1, 4'h2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
